// File: rtl/sram_wb_pkg.sv
// Shared types and constants for the Wishbone-to-byte-SRAM port 0 controller.
// Optional build macro used by the controller: SRAM_WB_ERR_EN (address decode error response).
package sram_wb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam int          LANES             = 4;
   localparam int          LANE_W            = $clog2(LANES);
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

   // Lowest-numbered set lane wins so lane 0 is always served first.
   function automatic logic [LANE_W-1:0] firstLane(input logic [LANES-1:0] mask);
      logic [LANE_W-1:0] lane;
      lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (mask[i]) begin
            lane = i[LANE_W-1:0];
         end
      end
      return lane;
   endfunction

endpackage

// File: rtl/sram_wb_port0_ctrl.sv
// Wishbone slave that splits each 32-bit access into one byte-wide SRAM access per selected lane.
// Define SRAM_WB_ERR_EN to answer accesses outside the BASE_ADDR window with wbs_err_o.
module sram_wb_port0_ctrl
   import sram_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
   parameter int          ADDR_WIDTH = 10,
   parameter int          DATA_WIDTH = 8
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [31:0]           wbs_dat_i,
   output logic [31:0]           wbs_dat_o,
   output logic                  wbs_ack_o,
   output logic                  wbs_err_o,
   output logic                  csb0_o,
   output logic                  web0_o,
   output logic [ADDR_WIDTH-1:0] addr0_o,
   output logic [DATA_WIDTH-1:0] din0_o,
   input  logic [DATA_WIDTH-1:0] dout0_i
);

   state_t                     r_state;
   logic [LANES-1:0]           r_pend;
   logic [LANE_W-1:0]          r_lane;
   logic                       r_we;
   logic [ADDR_WIDTH-LANE_W-1:0] r_adr;
   logic [31:0]                r_wdat;
   logic                       r_abort;
   logic                       r_csb;
   logic                       r_web;
   logic [ADDR_WIDTH-1:0]      r_addr;
   logic [DATA_WIDTH-1:0]      r_din;
   logic [31:0]                r_dat;
   logic                       r_ack;
   logic                       r_err;

   state_t                     w_stateNext;
   logic                       w_accept;
   logic                       w_toIssue;
   logic                       w_decErr;
   logic                       w_addrOk;
   logic [LANES-1:0]           w_src;
   logic [LANES-1:0]           w_laneBit;
   logic [LANE_W-1:0]          w_lane;
   logic                       w_issueWe;
   logic [ADDR_WIDTH-LANE_W-1:0] w_adrSrc;
   logic [31:0]                w_datSrc;
   logic                       w_unused;

`ifdef SRAM_WB_ERR_EN
   assign w_addrOk = (wbs_adr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
`else
   assign w_addrOk = 1'b1;
`endif

   assign w_unused = ^{wbs_adr_i[31:ADDR_WIDTH], wbs_adr_i[LANE_W-1:0]};

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A new request comes from the live bus in IDLE; later lanes come from the latched copy.
   always_comb begin
      w_stateNext = r_state;
      w_accept    = 1'b0;
      w_toIssue   = 1'b0;
      w_src       = r_pend;
      case (r_state)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               w_accept = 1'b1;
               w_src    = wbs_sel_i;
               if (!w_addrOk || wbs_sel_i == '0) begin
                  w_stateNext = ACK;
               end else begin
                  w_stateNext = ISSUE;
                  w_toIssue   = 1'b1;
               end
            end
         end
         ISSUE: begin
            w_stateNext = WAIT;
         end
         WAIT: begin
            if (r_abort || !wbs_cyc_i) begin
               w_stateNext = IDLE;
            end else if (r_pend != '0) begin
               w_stateNext = ISSUE;
               w_toIssue   = 1'b1;
            end else begin
               w_stateNext = ACK;
            end
         end
         ACK: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
      w_lane            = firstLane(w_src);
      w_laneBit         = '0;
      w_laneBit[w_lane] = 1'b1;
      w_decErr          = w_accept & ~w_addrOk;
      w_issueWe         = (r_state == IDLE) ? wbs_we_i : r_we;
      w_adrSrc          = (r_state == IDLE) ? wbs_adr_i[ADDR_WIDTH-1:LANE_W] : r_adr;
      w_datSrc          = (r_state == IDLE) ? wbs_dat_i : r_wdat;
   end

   // Read data is cleared on acceptance so lanes that are never read come back as zero.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_pend  <= '0;
         r_lane  <= '0;
         r_we    <= 1'b0;
         r_adr   <= '0;
         r_wdat  <= '0;
         r_abort <= 1'b0;
         r_csb   <= 1'b1;
         r_web   <= 1'b1;
         r_addr  <= '0;
         r_din   <= '0;
         r_dat   <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ack <= (w_stateNext == ACK) && !w_decErr;
         r_err <= w_decErr;
         if (w_accept) begin
            r_we    <= wbs_we_i;
            r_adr   <= wbs_adr_i[ADDR_WIDTH-1:LANE_W];
            r_wdat  <= wbs_dat_i;
            r_abort <= 1'b0;
            if (w_addrOk && (!wbs_we_i || wbs_sel_i == '0)) begin
               r_dat <= '0;
            end
         end else if ((r_state == ISSUE || r_state == WAIT) && !wbs_cyc_i) begin
            r_abort <= 1'b1;
         end
         if (w_toIssue) begin
            r_csb  <= 1'b0;
            r_web  <= ~w_issueWe;
            r_addr <= {w_adrSrc, w_lane};
            r_din  <= w_datSrc[DATA_WIDTH*w_lane +: DATA_WIDTH];
            r_pend <= w_src & ~w_laneBit;
            r_lane <= w_lane;
         end else begin
            r_csb <= 1'b1;
            r_web <= 1'b1;
         end
         // The SRAM presents the byte one cycle after ISSUE, so it is taken on the edge leaving WAIT.
         if (r_state == WAIT && !r_we) begin
            r_dat[DATA_WIDTH*r_lane +: DATA_WIDTH] <= dout0_i;
         end
      end
   end

   assign wbs_dat_o = r_dat;
   assign wbs_ack_o = r_ack;
   assign wbs_err_o = r_err;
   assign csb0_o    = r_csb;
   assign web0_o    = r_web;
   assign addr0_o   = r_addr;
   assign din0_o    = r_din;

endmodule

// File: tb/tb_sram_wb_port0_ctrl.sv
// Scoreboard bench for sram_wb_port0_ctrl with a byte-array SRAM model and a byte-level reference memory.
// Build with SRAM_WB_ERR_EN defined to expect decode errors outside the base window.
module tb_sram_wb_port0_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;

   typedef struct {
      bit          isErr;
      int          expEdge;
      logic [31:0] dat;
      logic [31:0] care;
      string       name;
   } exp_t;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
   logic        wbs_ack_o, wbs_err_o;
   logic        csb0_o, web0_o;
   logic [9:0]  addr0_o;
   logic [7:0]  din0_o;
   logic [7:0]  dout0_i = 8'h00;

   int   checks = 0;
   int   errors = 0;
   int   edgeCnt = 0;
   int   sramAccesses = 0;
   bit   memReady = 1'b0;
   bit   inAckCycle = 1'b0;
   logic [7:0]  sramMem [0:1023];
   logic [7:0]  refMem  [0:1023];
   logic [31:0] lastDat = 32'h0;
   exp_t scb[$];

   sram_wb_port0_ctrl dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .wbs_cyc_i(wbs_cyc_i),
      .wbs_stb_i(wbs_stb_i),
      .wbs_we_i (wbs_we_i),
      .wbs_sel_i(wbs_sel_i),
      .wbs_adr_i(wbs_adr_i),
      .wbs_dat_i(wbs_dat_i),
      .wbs_dat_o(wbs_dat_o),
      .wbs_ack_o(wbs_ack_o),
      .wbs_err_o(wbs_err_o),
      .csb0_o   (csb0_o),
      .web0_o   (web0_o),
      .addr0_o  (addr0_o),
      .din0_o   (din0_o),
      .dout0_i  (dout0_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(posedge wb_clk_i) edgeCnt++;

   function automatic logic [7:0] initByte(input int i);
      return 8'((i * 37) + 5);
   endfunction

   // Synchronous byte SRAM: samples csb/web/addr/din on the clock, read byte valid the next cycle.
   always @(posedge wb_clk_i) begin
      if (!memReady) begin
         for (int i = 0; i < 1024; i++) sramMem[i] <= initByte(i);
         memReady <= 1'b1;
      end else if (!csb0_o) begin
         sramAccesses++;
         if (!web0_o) sramMem[addr0_o] <= din0_o;
         else         dout0_i <= sramMem[addr0_o];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Monitor: every ack/err pops one expectation and checks kind, edge and read data.
   always @(negedge wb_clk_i) begin
      exp_t e;
      if (!wb_rst_i && (wbs_ack_o || wbs_err_o)) begin
         checkOutput("ackErrExclusive", {31'b0, wbs_ack_o & wbs_err_o}, 32'd0);
         if (scb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedResponse: got ack=%0b err=%0b at edge %0d expected none",
                     wbs_ack_o, wbs_err_o, edgeCnt);
         end else begin
            e = scb.pop_front();
            checkOutput({e.name, "_kind"}, {30'b0, wbs_err_o, wbs_ack_o}, e.isErr ? 32'd2 : 32'd1);
            checkOutput({e.name, "_edge"}, 32'(edgeCnt), 32'(e.expEdge));
            checkOutput({e.name, "_dat"}, wbs_dat_o & e.care, e.dat & e.care);
         end
      end
   end

   // Reference model works on whole requests: decode, count lanes, update/gather bytes.
   task automatic applyStimulus(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                                input logic [31:0] dat, input bit hold, input logic [31:0] care,
                                input string name);
      exp_t e;
      int   k, acceptEdge, accBefore, idx;
      bit   addrOk, seen;
      k = $countones(sel);
`ifdef SRAM_WB_ERR_EN
      addrOk = (adr[31:10] == BASE[31:10]);
`else
      addrOk = 1'b1;
`endif
      if (addrOk) begin
         if (sel == 4'h0) lastDat = 32'h0;
         else if (!we) lastDat = 32'h0;
         for (int l = 0; l < 4; l++) begin
            idx = {adr[9:2], 2'(l)};
            if (sel[l]) begin
               if (we) refMem[idx] = dat[8*l +: 8];
               else    lastDat[8*l +: 8] = refMem[idx];
            end
         end
      end
      acceptEdge = edgeCnt + (inAckCycle ? 2 : 1);
      e.isErr   = !addrOk;
      e.expEdge = acceptEdge + (addrOk ? 2 * k : 0);
      e.dat     = lastDat;
      e.care    = care;
      e.name    = name;
      scb.push_back(e);
      accBefore = sramAccesses;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o || wbs_err_o) seen = 1'b1;
         else if (edgeCnt >= acceptEdge) begin
            wbs_adr_i = $urandom; wbs_dat_i = $urandom;
            wbs_sel_i = 4'($urandom); wbs_we_i = 1'($urandom);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: got no response expected one by edge %0d", name, e.expEdge);
         scb.delete();
         hold = 1'b0;
      end
      checkOutput({name, "_sramAccesses"}, 32'(sramAccesses - accBefore), addrOk ? 32'(k) : 32'd0);
      if (hold) begin
         inAckCycle = 1'b1;
      end else begin
         wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
         @(negedge wb_clk_i);
         inAckCycle = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] oldB2;
      logic [31:0] rstDat;
      int accBefore;
      for (int i = 0; i < 1024; i++) refMem[i] = initByte(i);
      wb_rst_i = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
      repeat (3) @(negedge wb_clk_i);
      checkOutput("rstCsb", {31'b0, csb0_o}, 32'd1);
      checkOutput("rstWeb", {31'b0, web0_o}, 32'd1);
      checkOutput("rstAddr", {22'b0, addr0_o}, 32'd0);
      checkOutput("rstDat", wbs_dat_o, 32'd0);
      checkOutput("rstAckErr", {30'b0, wbs_ack_o, wbs_err_o}, 32'd0);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);

      applyStimulus(1'b1, 4'hF, 32'h3000_0010, 32'hA1B2C3D4, 1'b0, '1, "req037Write");
      checkOutput("req037Byte10", {24'b0, sramMem[10'h10]}, 32'hD4);
      checkOutput("req037Byte11", {24'b0, sramMem[10'h11]}, 32'hC3);
      checkOutput("req037Byte12", {24'b0, sramMem[10'h12]}, 32'hB2);
      checkOutput("req037Byte13", {24'b0, sramMem[10'h13]}, 32'hA1);
      applyStimulus(1'b0, 4'h5, 32'h3000_0010, 32'h0, 1'b0, '1, "req038Read");
      checkOutput("req038Hold", wbs_dat_o, 32'h00B2_00D4);
      applyStimulus(1'b0, 4'h0, 32'h3000_0020, 32'h0, 1'b0, '1, "req039Sel0");
      applyStimulus(1'b0, 4'hF, 32'h2000_0000, 32'h0, 1'b0, '1, "upperAddr");

      // Abort: drop cyc during the first WAIT of a four-lane read.
      accBefore = sramAccesses;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0040; wbs_dat_i = 32'h0;
      repeat (2) @(negedge wb_clk_i);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(negedge wb_clk_i);
      lastDat = {24'b0, refMem[10'h40]};
      checkOutput("abortAccesses", 32'(sramAccesses - accBefore), 32'd1);
      applyStimulus(1'b0, 4'h3, 32'h3000_0044, 32'h0, 1'b0, '1, "afterAbortRead");

      // Reset during the third lane of a write.
      oldB2 = refMem[10'h52];
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0050; wbs_dat_i = 32'h5566_7788;
      repeat (5) @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      #1;
      checkOutput("midRstCsb", {31'b0, csb0_o}, 32'd1);
      checkOutput("midRstWeb", {31'b0, web0_o}, 32'd1);
      checkOutput("midRstAddr", {22'b0, addr0_o}, 32'd0);
      checkOutput("midRstDin", {24'b0, din0_o}, 32'd0);
      checkOutput("midRstDat", wbs_dat_o, 32'd0);
      checkOutput("midRstAckErr", {30'b0, wbs_ack_o, wbs_err_o}, 32'd0);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      inAckCycle = 1'b0;
      @(negedge wb_clk_i);
      refMem[10'h50] = 8'h88;
      refMem[10'h51] = 8'h77;
      lastDat = 32'h0;
      checkOutput("midRstByte2OldOrNew",
                  {31'b0, (sramMem[10'h52] === oldB2) || (sramMem[10'h52] === 8'h66)}, 32'd1);
      applyStimulus(1'b0, 4'hF, 32'h3000_0050, 32'h0, 1'b0, 32'hFF00_FFFF, "afterRstRead");
      rstDat = $urandom;
      applyStimulus(1'b1, 4'hF, 32'h3000_0050, rstDat, 1'b0, '1, "resyncWrite");

      for (int n = 0; n < 60; n++) begin
         applyStimulus(1'($urandom), 4'($urandom), BASE | (32'($urandom_range(0, 15)) << 2),
                       $urandom, (n != 59) && 1'($urandom), '1, "random");
      end

      repeat (4) @(negedge wb_clk_i);
      checkOutput("scoreboardEmpty", 32'(scb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
